// File: rtl/sr_btn_conditioner_pkg.sv
// Shared definitions for the RS-trigger button conditioner: FSM state encoding
// and default timing parameters.
package sr_btn_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam int DEF_DB_CYCLES    = 16;
    localparam int DEF_PULSE_CYCLES = 4;

endpackage

// File: rtl/sr_btn_conditioner_debounce.sv
// One button channel: 2-flop synchroniser, stability counter and press-edge
// detector. Releases are filtered the same way but produce no output.
module btn_debounce
    import sr_btn_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_p0  <= btn;
            sync_p1  <= sync_p0;
            stable_d <= stable;
            // Any return to the accepted level restarts the stability window.
            if (sync_p1 != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= sync_p1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = stable & ~stable_d;

endmodule

// File: rtl/sr_btn_conditioner.sv
// Turns two bouncing buttons into clean, mutually exclusive S/R pulses for the
// RS trigger, with a one-deep pending slot for the opposite channel.
module sr_btn_conditioner
    import sr_btn_conditioner_pkg::*;
#(
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_s,
    input  logic btn_r,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict
);

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PCNT_LOAD = PW'(PULSE_CYCLES - 1);

    logic          rise_s;
    logic          rise_r;
    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;
    logic          pend;
    logic          pend_nxt;
    logic          last_s;
    logic          last_s_nxt;
    logic          conflict_nxt;
    logic          opp_rise;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_s (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_s),
        .rise (rise_s)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_r),
        .rise (rise_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            pend     <= 1'b0;
            last_s   <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_nxt;
            pcnt     <= pcnt_nxt;
            pend     <= pend_nxt;
            last_s   <= last_s_nxt;
            S        <= (state_nxt == PULSE_S);
            R        <= (state_nxt == PULSE_R);
            conflict <= conflict_nxt;
        end
    end

    // In GAP the only request worth serving is the channel that did not just pulse.
    assign opp_rise = last_s ? rise_r : rise_s;

    always_comb begin
        state_nxt    = state;
        pcnt_nxt     = pcnt;
        pend_nxt     = pend;
        last_s_nxt   = last_s;
        conflict_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (rise_s && rise_r) begin
                    conflict_nxt = 1'b1;
                end else if (rise_s) begin
                    state_nxt  = PULSE_S;
                    pcnt_nxt   = PCNT_LOAD;
                    last_s_nxt = 1'b1;
                end else if (rise_r) begin
                    state_nxt  = PULSE_R;
                    pcnt_nxt   = PCNT_LOAD;
                    last_s_nxt = 1'b0;
                end
            end
            PULSE_S, PULSE_R: begin
                if ((state == PULSE_S) ? rise_r : rise_s) begin
                    pend_nxt = 1'b1;
                end
                if (pcnt == '0) begin
                    state_nxt = GAP;
                end else begin
                    pcnt_nxt = pcnt - PW'(1);
                end
            end
            default: begin
                if (pend || opp_rise) begin
                    state_nxt  = last_s ? PULSE_R : PULSE_S;
                    pcnt_nxt   = PCNT_LOAD;
                    last_s_nxt = ~last_s;
                    pend_nxt   = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_sr_btn_conditioner.sv
// Bench for sr_btn_conditioner: per-scenario stimulus/expectation records,
// expected outputs queued when driven and compared one edge later.
module tb_sr_btn_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_s = 1'b0;
    logic btn_r = 1'b0;
    logic S, R, busy, conflict;

    int checks = 0;
    int errors = 0;
    logic [3:0] sb_q[$];

    sr_btn_conditioner #(.DB_CYCLES(16), .PULSE_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_s    (btn_s),
        .btn_r    (btn_r),
        .S        (S),
        .R        (R),
        .busy     (busy),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    // Windows are inclusive edge indices after which the output is high; -1 = none.
    typedef struct {
        int id;
        int n;
        int s_on, s_off, r_on, r_off, rst_on, rst_off, bounce_end;
        int s_a, s_b, s2_a, s2_b, r_a, r_b, b_a, b_b, b2_a, b2_b, conf_at;
    } vec_t;

    vec_t tbl[11];

    function automatic bit inw(input int k, input int a, input int b);
        return (a >= 0) && (k >= a) && (k <= b);
    endfunction

    task automatic check_edge(input int id, input int k);
        logic [3:0] exp;
        logic [3:0] got;
        exp = sb_q.pop_front();
        got = {S, R, busy, conflict};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL vec%0d cyc%0d {S,R,busy,conflict}: got %b required %b", id, k, got, exp);
        end
        checks++;
        if (S && R) begin
            errors++;
            $display("FAIL vec%0d cyc%0d S_R_exclusive: got S=%b R=%b required not both 1", id, k, S, R);
        end
    endtask

    task automatic do_reset(input int id);
        rst   = 1'b1;
        btn_s = 1'b0;
        btn_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(4'b0000);
            @(posedge clk);
            #1;
            check_edge(id, -1 - i);
        end
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] exp;
        do_reset(v.id);
        for (int k = 0; k < v.n; k++) begin
            if (k < v.bounce_end)
                btn_s = ((k / 5) % 2 == 0);
            else
                btn_s = (k >= v.s_on) && (k < v.s_off);
            btn_r = (k >= v.r_on) && (k < v.r_off);
            rst   = (k >= v.rst_on) && (k < v.rst_off);
            exp[3] = inw(k, v.s_a, v.s_b) | inw(k, v.s2_a, v.s2_b);
            exp[2] = inw(k, v.r_a, v.r_b);
            exp[1] = inw(k, v.b_a, v.b_b) | inw(k, v.b2_a, v.b2_b);
            exp[0] = (k == v.conf_at);
            sb_q.push_back(exp);
            @(posedge clk);
            #1;
            check_edge(v.id, k);
        end
        rst = 1'b0;
    endtask

    initial begin
        //           id  n   s_on s_off r_on r_off rst_on rst_off bnc  s_a s_b s2_a s2_b r_a r_b b_a b_b b2_a b2_b conf
        tbl[0]  = '{0,  30,  -1,  -1,  -1,  -1,  -1,  -1,  0,  -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        tbl[1]  = '{1,  80,   0,  40,  -1,  -1,  -1,  -1,  0,  18, 21, -1, -1, -1, -1, 18, 22, -1, -1, -1};
        tbl[2]  = '{2,  40,  -1,  -1,   0,  40,  -1,  -1,  0,  -1, -1, -1, -1, 18, 21, 18, 22, -1, -1, -1};
        tbl[3]  = '{3,  40,   0,  60,   3,  60,  -1,  -1,  0,  18, 21, -1, -1, 23, 26, 18, 27, -1, -1, -1};
        tbl[4]  = '{4,  40,   0,  40,   0,  40,  -1,  -1,  0,  -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 18};
        tbl[5]  = '{5,  40,   2,  60,   0,  60,  -1,  -1,  0,  23, 26, -1, -1, 18, 21, 18, 27, -1, -1, -1};
        tbl[6]  = '{6,  45,   0,  60,  10,  60,  -1,  -1,  0,  18, 21, -1, -1, 28, 31, 18, 22, 28, 32, -1};
        tbl[7]  = '{7,  40,   0,  60,   5,  60,  -1,  -1,  0,  18, 21, -1, -1, 23, 26, 18, 27, -1, -1, -1};
        tbl[8]  = '{8,  40,   0,  60,   4,  60,  -1,  -1,  0,  18, 21, -1, -1, 23, 26, 18, 27, -1, -1, -1};
        // Bounce shorter than the debounce window, then a steady press.
        tbl[9]  = '{9, 100,  60, 200,  -1,  -1,  -1,  -1, 60,  78, 81, -1, -1, -1, -1, 78, 82, -1, -1, -1};
        // Reset lands in the second S cycle; the held button re-triggers once.
        tbl[10] = '{10, 60,   0,  80,  -1,  -1,  20,  22,  0,  18, 19, 40, 43, -1, -1, 18, 19, 40, 44, -1};

        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
